// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM states and the destination scoreboard entry.
package hazard_ctrl_pkg;

   localparam int HZ_REG_AW = 5;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic                 valid;
      logic [HZ_REG_AW-1:0] rd;
      logic                 we;
      logic                 is_load;
      logic                 is_md;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Priority match of one EXE source against the post-EXE
// scoreboard entries; the nearest producing stage wins.
module hz_fwd_match
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW     = HZ_REG_AW,
   parameter int FWD_STAGES = 2,
   parameter int SEL_W      = $clog2(FWD_STAGES+1)
) (
   input  logic [REG_AW-1:0] i_src,
   input  sb_entry_t         i_sb [0:FWD_STAGES],
   output logic [SEL_W-1:0]  o_sel
);

   // Scan farthest to nearest so the smallest stage index is kept
   always_comb begin
      o_sel = '0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (i_sb[k].valid && i_sb[k].we &&
             (i_sb[k].rd == i_src) && (i_src != '0))
            o_sel = SEL_W'(k);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubbles,
// operand forwarding selects and the mul/div handshake.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter  int REG_AW     = HZ_REG_AW,
   parameter  int FWD_STAGES = 2,
   parameter  int MD_TIMEOUT = 64,
   localparam int FWD_SEL_W  = $clog2(FWD_STAGES+1)
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 dec_valid,
   input  logic [REG_AW-1:0]    dec_rs1,
   input  logic [REG_AW-1:0]    dec_rs2,
   input  logic                 dec_rs1_used,
   input  logic                 dec_rs2_used,
   input  logic [REG_AW-1:0]    dec_rd,
   input  logic                 dec_rd_we,
   input  logic                 dec_is_load,
   input  logic                 dec_is_muldiv,
   input  logic                 icache_miss,
   input  logic                 redirect,
   input  logic                 muldiv_done,
   output logic                 pc_en,
   output logic                 fd_en,
   output logic                 de_en,
   output logic                 em_en,
   output logic                 mw_en,
   output logic                 fd_bubble,
   output logic                 de_bubble,
   output logic                 em_bubble,
   output logic                 muldiv_start,
   output logic [FWD_SEL_W-1:0] fwd_sel1,
   output logic [FWD_SEL_W-1:0] fwd_sel2,
   output logic                 muldiv_timeout
);

   localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

   hz_state_t        r_state;
   hz_state_t        w_state_nx;
   sb_entry_t        r_sb [0:FWD_STAGES];
   logic [REG_AW-1:0] r_rs1_e;
   logic [REG_AW-1:0] r_rs2_e;
   logic [CW-1:0]    r_cnt;

   logic                 w_md_start;
   logic                 w_md_fin;
   logic                 w_md_to;
   logic                 w_ld_use;
   logic                 w_rs_hit;
   logic [FWD_SEL_W-1:0] w_fwd1;
   logic [FWD_SEL_W-1:0] w_fwd2;

   assign w_md_start = (r_state == RUN) && r_sb[0].valid &&
                       r_sb[0].is_md;
   assign w_md_to    = (r_state == MD_BUSY) && !muldiv_done &&
                       (r_cnt == CNT_LAST);
   assign w_md_fin   = (r_state == MD_BUSY) &&
                       (muldiv_done || (r_cnt == CNT_LAST));
   assign w_rs_hit   = (dec_rs1_used && (dec_rs1 == r_sb[0].rd)) ||
                       (dec_rs2_used && (dec_rs2 == r_sb[0].rd));
   assign w_ld_use   = (r_state == RUN) && !w_md_start &&
                       r_sb[0].valid && r_sb[0].is_load &&
                       (r_sb[0].rd != '0) && w_rs_hit;

   hz_fwd_match #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (FWD_SEL_W)
   ) u_fwd1 (
      .i_src (r_rs1_e),
      .i_sb  (r_sb),
      .o_sel (w_fwd1)
   );

   hz_fwd_match #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (FWD_SEL_W)
   ) u_fwd2 (
      .i_src (r_rs2_e),
      .i_sb  (r_sb),
      .o_sel (w_fwd2)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!nrst) r_state <= RUN;
      else       r_state <= w_state_nx;
   end

   // FSM next state: enter on start, leave on done or timeout
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         RUN:     if (w_md_start) w_state_nx = MD_BUSY;
         MD_BUSY: if (w_md_fin)   w_state_nx = RUN;
         default: w_state_nx = RUN;
      endcase
   end

   // Enables and bubbles by priority: reset, mul/div, load-use, miss, redirect
   always_comb begin
      pc_en          = 1'b1;
      fd_en          = 1'b1;
      de_en          = 1'b1;
      em_en          = 1'b1;
      mw_en          = 1'b1;
      fd_bubble      = 1'b0;
      de_bubble      = 1'b0;
      em_bubble      = 1'b0;
      muldiv_start   = 1'b0;
      muldiv_timeout = 1'b0;
      fwd_sel1       = '0;
      fwd_sel2       = '0;
      if (nrst) begin
         fwd_sel1 = w_fwd1;
         fwd_sel2 = w_fwd2;
         if (r_state == MD_BUSY) begin
            pc_en          = 1'b0;
            fd_en          = 1'b0;
            de_en          = 1'b0;
            em_bubble      = !w_md_fin;
            muldiv_timeout = w_md_to;
         end else if (w_md_start) begin
            pc_en        = 1'b0;
            fd_en        = 1'b0;
            de_en        = 1'b0;
            em_bubble    = 1'b1;
            muldiv_start = 1'b1;
         end else if (w_ld_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
         end else if (icache_miss) begin
            pc_en     = 1'b0;
            fd_bubble = 1'b1;
         end else if (redirect) begin
            fd_bubble = 1'b1;
         end
      end
   end

   // Mul/div wait counter, cleared at start and on completion
   always_ff @(posedge clk) begin
      if (!nrst)
         r_cnt <= '0;
      else if (w_md_start || w_md_fin)
         r_cnt <= '0;
      else if (r_state == MD_BUSY)
         r_cnt <= r_cnt + 1'b1;
   end

   // Scoreboard: load EXE from decode, shift the post-EXE entries
   always_ff @(posedge clk) begin
      if (!nrst) begin
         for (int k = 0; k <= FWD_STAGES; k++)
            r_sb[k] <= SB_EMPTY;
         r_rs1_e <= '0;
         r_rs2_e <= '0;
      end else begin
         if (de_en) begin
            if (de_bubble || !dec_valid)
               r_sb[0] <= SB_EMPTY;
            else
               r_sb[0] <= '{valid:   1'b1,
                            rd:      dec_rd,
                            we:      dec_rd_we,
                            is_load: dec_is_load,
                            is_md:   dec_is_muldiv};
            r_rs1_e <= dec_rs1;
            r_rs2_e <= dec_rs2;
         end else if (w_md_fin) begin
            // the finished mul/div has moved into MEM
            r_sb[0].valid <= 1'b0;
         end
         if (em_en) begin
            r_sb[1] <= em_bubble ? SB_EMPTY : r_sb[0];
            for (int k = 2; k <= FWD_STAGES; k++)
               r_sb[k] <= r_sb[k-1];
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios
// plus random stimulus against an instruction-level model.
module tb_hazard_ctrl;

   localparam int AW  = 5;
   localparam int NS  = 3;
   localparam int MDT = 16;
   localparam int SW  = $clog2(NS+1);

   logic          clk = 1'b0;
   logic          nrst;
   logic          dec_valid;
   logic [AW-1:0] dec_rs1;
   logic [AW-1:0] dec_rs2;
   logic          dec_rs1_used;
   logic          dec_rs2_used;
   logic [AW-1:0] dec_rd;
   logic          dec_rd_we;
   logic          dec_is_load;
   logic          dec_is_muldiv;
   logic          icache_miss;
   logic          redirect;
   logic          muldiv_done;
   logic          pc_en, fd_en, de_en, em_en, mw_en;
   logic          fd_bubble, de_bubble, em_bubble;
   logic          muldiv_start, muldiv_timeout;
   logic [SW-1:0] fwd_sel1, fwd_sel2;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REG_AW     (AW),
      .FWD_STAGES (NS),
      .MD_TIMEOUT (MDT)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .dec_valid      (dec_valid),
      .dec_rs1        (dec_rs1),
      .dec_rs2        (dec_rs2),
      .dec_rs1_used   (dec_rs1_used),
      .dec_rs2_used   (dec_rs2_used),
      .dec_rd         (dec_rd),
      .dec_rd_we      (dec_rd_we),
      .dec_is_load    (dec_is_load),
      .dec_is_muldiv  (dec_is_muldiv),
      .icache_miss    (icache_miss),
      .redirect       (redirect),
      .muldiv_done    (muldiv_done),
      .pc_en          (pc_en),
      .fd_en          (fd_en),
      .de_en          (de_en),
      .em_en          (em_en),
      .mw_en          (mw_en),
      .fd_bubble      (fd_bubble),
      .de_bubble      (de_bubble),
      .em_bubble      (em_bubble),
      .muldiv_start   (muldiv_start),
      .fwd_sel1       (fwd_sel1),
      .fwd_sel2       (fwd_sel2),
      .muldiv_timeout (muldiv_timeout)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input int exp);
      n_chk++;
      if (obs !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   // ---- instruction-level reference model ----
   typedef struct {
      bit v;
      int rd;
      bit we;
      bit ld;
      bit md;
   } minst_t;

   minst_t m_exe;
   int     m_rs1, m_rs2;
   minst_t m_pipe[$];
   bit     m_busy;
   int     m_age;

   bit e_pc, e_fd, e_de, e_em, e_mw;
   bit e_fb, e_db, e_eb, e_st, e_to;
   int e_f1, e_f2;

   function automatic minst_t empty_inst();
      minst_t t;
      t.v = 0; t.rd = 0; t.we = 0; t.ld = 0; t.md = 0;
      return t;
   endfunction

   function automatic int fwd_of(int src);
      for (int k = 0; k < m_pipe.size(); k++)
         if (m_pipe[k].v && m_pipe[k].we &&
             m_pipe[k].rd == src && src != 0)
            return k + 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_exe  = empty_inst();
      m_rs1  = 0;
      m_rs2  = 0;
      m_pipe.delete();
      m_busy = 0;
      m_age  = 0;
   endtask

   task automatic model_eval();
      bit hit;
      e_pc = 1; e_fd = 1; e_de = 1; e_em = 1; e_mw = 1;
      e_fb = 0; e_db = 0; e_eb = 0; e_st = 0; e_to = 0;
      e_f1 = 0; e_f2 = 0;
      hit = (dec_rs1_used && int'(dec_rs1) == m_exe.rd) ||
            (dec_rs2_used && int'(dec_rs2) == m_exe.rd);
      if (nrst) begin
         e_f1 = fwd_of(m_rs1);
         e_f2 = fwd_of(m_rs2);
         if (m_busy) begin
            e_pc = 0; e_fd = 0; e_de = 0;
            e_eb = !(muldiv_done || m_age == MDT);
            e_to = !muldiv_done && m_age == MDT;
         end else if (m_exe.v && m_exe.md) begin
            e_pc = 0; e_fd = 0; e_de = 0;
            e_eb = 1; e_st = 1;
         end else if (m_exe.v && m_exe.ld && m_exe.rd != 0 && hit) begin
            e_pc = 0; e_fd = 0; e_db = 1;
         end else if (icache_miss) begin
            e_pc = 0; e_fb = 1;
         end else if (redirect) begin
            e_fb = 1;
         end
      end
   endtask

   task automatic model_clk();
      bit     fin;
      minst_t d;
      if (!nrst) begin
         model_reset();
         return;
      end
      fin = m_busy && (muldiv_done || m_age == MDT);
      if (e_em) begin
         m_pipe.push_front(e_eb ? empty_inst() : m_exe);
         if (m_pipe.size() > NS) void'(m_pipe.pop_back());
      end
      if (e_de) begin
         d = empty_inst();
         if (dec_valid && !e_db) begin
            d.v  = 1;
            d.rd = int'(dec_rd);
            d.we = dec_rd_we;
            d.ld = dec_is_load;
            d.md = dec_is_muldiv;
         end
         m_exe = d;
         m_rs1 = int'(dec_rs1);
         m_rs2 = int'(dec_rs2);
      end else if (fin) begin
         m_exe.v = 0;
      end
      if (e_st) begin
         m_busy = 1;
         m_age  = 1;
      end else if (m_busy) begin
         if (fin) m_busy = 0;
         else     m_age++;
      end
   endtask

   // ---- cycle helpers ----
   task automatic step_eval();
      #3;
      model_eval();
      chk("pc_en",     pc_en,          e_pc);
      chk("fd_en",     fd_en,          e_fd);
      chk("de_en",     de_en,          e_de);
      chk("em_en",     em_en,          e_em);
      chk("mw_en",     mw_en,          e_mw);
      chk("fd_bubble", fd_bubble,      e_fb);
      chk("de_bubble", de_bubble,      e_db);
      chk("em_bubble", em_bubble,      e_eb);
      chk("md_start",  muldiv_start,   e_st);
      chk("md_tout",   muldiv_timeout, e_to);
      chk("fwd_sel1",  fwd_sel1,       e_f1);
      chk("fwd_sel2",  fwd_sel2,       e_f2);
   endtask

   task automatic step_clk();
      @(posedge clk);
      model_clk();
      #1;
   endtask

   task automatic step();
      step_eval();
      step_clk();
   endtask

   task automatic idle();
      nrst          = 1;
      dec_valid     = 0;
      dec_rs1       = '0;
      dec_rs2       = '0;
      dec_rs1_used  = 0;
      dec_rs2_used  = 0;
      dec_rd        = '0;
      dec_rd_we     = 0;
      dec_is_load   = 0;
      dec_is_muldiv = 0;
      icache_miss   = 0;
      redirect      = 0;
      muldiv_done   = 0;
   endtask

   task automatic put_inst(input int rd, input bit we,
                           input int rs1, input int rs2,
                           input bit ld, input bit md);
      dec_valid     = 1;
      dec_rd        = AW'(rd);
      dec_rd_we     = we;
      dec_rs1       = AW'(rs1);
      dec_rs2       = AW'(rs2);
      dec_rs1_used  = 1;
      dec_rs2_used  = 1;
      dec_is_load   = ld;
      dec_is_muldiv = md;
   endtask

   initial begin
      int got;
      int r;
      model_reset();
      idle();
      nrst = 0;
      step_eval();
      chk("rst_pc", pc_en, 1);
      chk("rst_st", muldiv_start, 0);
      step_clk();
      step();
      idle();
      step_eval();
      chk("rst_mw", mw_en, 1);
      step_clk();

      // forward from MEM, back to back
      put_inst(5, 1, 0, 0, 0, 0);
      step();
      put_inst(6, 1, 5, 5, 0, 0);
      step();
      idle();
      step_eval();
      chk("mem_f1", fwd_sel1, 1);
      chk("mem_f2", fwd_sel2, 1);
      chk("mem_pc", pc_en, 1);
      step_clk();

      // nearest stage wins, x0 never forwards
      put_inst(7, 1, 0, 0, 0, 0); step();
      put_inst(0, 1, 0, 0, 0, 0); step();
      put_inst(7, 1, 0, 0, 0, 0); step();
      put_inst(9, 1, 7, 0, 0, 0); step();
      idle();
      step_eval();
      chk("pri_f1", fwd_sel1, 1);
      chk("pri_x0", fwd_sel2, 0);
      step_clk();

      // load-use with a redirect in the stall cycle
      put_inst(3, 1, 0, 0, 1, 0);
      step();
      put_inst(4, 1, 3, 0, 0, 0);
      redirect = 1;
      step_eval();
      chk("lu_pc",  pc_en, 0);
      chk("lu_fd",  fd_en, 0);
      chk("lu_de",  de_en, 1);
      chk("lu_db",  de_bubble, 1);
      chk("lu_rdr", fd_bubble, 0);
      step_clk();
      redirect = 0;
      step_eval();
      chk("lu_one", pc_en, 1);
      chk("lu_fwd", fwd_sel1, 1);
      step_clk();
      idle();
      step_eval();
      chk("lu_wb", fwd_sel1, 2);
      step_clk();

      // mul/div completing after 10 cycles
      put_inst(9, 1, 0, 0, 0, 1);
      step();
      idle();
      step_eval();
      chk("md_st", muldiv_start, 1);
      chk("md_pc", pc_en, 0);
      step_clk();
      for (int i = 1; i < 10; i++) step();
      muldiv_done = 1;
      step_eval();
      chk("md_em", em_en, 1);
      chk("md_eb", em_bubble, 0);
      chk("md_de", de_en, 0);
      step_clk();
      muldiv_done = 0;
      step_eval();
      chk("md_back", pc_en, 1);
      chk("md_once", muldiv_start, 0);
      step_clk();
      step();

      // mul/div timeout
      put_inst(10, 1, 0, 0, 0, 1);
      step();
      idle();
      got = -1;
      for (int i = 0; i < 40 && got < 0; i++) begin
         step_eval();
         if (muldiv_timeout) got = i;
         step_clk();
      end
      chk("to_lat", got, MDT);
      step_eval();
      chk("to_run", pc_en, 1);
      step_clk();

      // reset in the middle of a mul/div
      put_inst(11, 1, 0, 0, 0, 1);
      step();
      idle();
      step(); step(); step();
      nrst = 0;
      step_eval();
      chk("rmd_pc", pc_en, 1);
      chk("rmd_st", muldiv_start, 0);
      step_clk();
      nrst = 1;
      step_eval();
      chk("rmd_de", de_en, 1);
      chk("rmd_st2", muldiv_start, 0);
      step_clk();

      // random traffic
      for (int c = 0; c < 2000; c++) begin
         nrst          = ($urandom_range(0, 99) != 0);
         dec_valid     = ($urandom_range(0, 3) != 0);
         dec_rd        = AW'($urandom_range(0, 4));
         dec_rs1       = AW'($urandom_range(0, 4));
         dec_rs2       = AW'($urandom_range(0, 4));
         dec_rs1_used  = $urandom_range(0, 1) != 0;
         dec_rs2_used  = $urandom_range(0, 1) != 0;
         dec_rd_we     = ($urandom_range(0, 3) != 0);
         r             = $urandom_range(0, 15);
         dec_is_load   = (r < 4);
         dec_is_muldiv = (r == 4);
         icache_miss   = ($urandom_range(0, 6) == 0);
         redirect      = ($urandom_range(0, 6) == 0);
         muldiv_done   = ($urandom_range(0, 11) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
